// File: rtl/warp_issue_queue.sv
// warp_issue_queue: in-order circular issue queue with a register scoreboard.
// One micro-op issues per cycle from the head to one of three unit classes
// (arith/logic/shift) once its source and destination registers are free.
// Optional feature macro: WARP_ISSUE_WB_BYPASS_EN -- when defined, a
// writeback in the current cycle unblocks a dependent head combinationally;
// when undefined, only the registered busy bits are consulted.
module warp_issue_queue #(
  parameter  int DEPTH = 8,
  parameter  int UOP_W = 64,
  parameter  int NREGS = 32,
  localparam int RW    = $clog2(NREGS),
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [UOP_W-1:0] i_in_uop,
  input  logic [1:0]       i_in_unit,
  input  logic [RW-1:0]    i_in_rd,
  input  logic [RW-1:0]    i_in_rs1,
  input  logic [RW-1:0]    i_in_rs2,
  input  logic             i_in_rd_en,
  output logic             o_arith_valid,
  output logic             o_logic_valid,
  output logic             o_shift_valid,
  input  logic             i_arith_ready,
  input  logic             i_logic_ready,
  input  logic             i_shift_ready,
  output logic [UOP_W-1:0] o_issue_uop,
  input  logic             i_wb_valid,
  input  logic [RW-1:0]    i_wb_rd,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count
);

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_SHIFT = 2'd2;
  localparam logic [1:0] UNIT_BAD   = 2'd3;

  // Entry storage (payload and decoded operand fields)
  logic [UOP_W-1:0] uop_mem_q   [DEPTH];
  logic [1:0]       unit_mem_q  [DEPTH];
  logic [RW-1:0]    rd_mem_q    [DEPTH];
  logic [RW-1:0]    rs1_mem_q   [DEPTH];
  logic [RW-1:0]    rs2_mem_q   [DEPTH];
  logic             rd_en_mem_q [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] set_hit;
  logic [NREGS-1:0] busy_view;

  logic             not_empty;
  logic             hazard;
  logic             sel_ready;
  logic             enq;
  logic             issue;

  logic [1:0]       head_unit;
  logic [RW-1:0]    head_rd;
  logic [RW-1:0]    head_rs1;
  logic [RW-1:0]    head_rs2;
  logic             head_rd_en;

  assign head_unit  = unit_mem_q[head_q];
  assign head_rd    = rd_mem_q[head_q];
  assign head_rs1   = rs1_mem_q[head_q];
  assign head_rs2   = rs2_mem_q[head_q];
  assign head_rd_en = rd_en_mem_q[head_q];

  assign not_empty  = (count_q != '0);
  assign o_in_ready = (count_q < CW'(DEPTH));
  assign o_count    = count_q;

  // Per-register writeback-clear and issue-set strobes; register 0 is hardwired free.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign wb_hit[gi]  = 1'b0;
        assign set_hit[gi] = 1'b0;
      end else begin : g_reg
        assign wb_hit[gi]  = i_wb_valid && (i_wb_rd == RW'(gi));
        assign set_hit[gi] = issue && head_rd_en && (head_rd == RW'(gi));
      end
    end
  endgenerate

`ifdef WARP_ISSUE_WB_BYPASS_EN
  assign busy_view = busy_q & ~wb_hit;
`else
  assign busy_view = busy_q;
`endif

  // Issue-set takes priority over a same-cycle writeback clear.
  assign busy_d = (busy_q & ~wb_hit) | set_hit;

  assign hazard = busy_view[head_rs1] || busy_view[head_rs2] ||
                  (head_rd_en && busy_view[head_rd]);

  assign o_arith_valid = not_empty && !hazard && (head_unit == UNIT_ARITH);
  assign o_logic_valid = not_empty && !hazard && (head_unit == UNIT_LOGIC);
  assign o_shift_valid = not_empty && !hazard && (head_unit == UNIT_SHIFT);

  assign o_issue_uop = not_empty ? uop_mem_q[head_q] : '0;

  // Route the ready of whichever unit class the head targets.
  always_comb begin
    sel_ready = 1'b0;
    case (head_unit)
      UNIT_ARITH: sel_ready = i_arith_ready;
      UNIT_LOGIC: sel_ready = i_logic_ready;
      UNIT_SHIFT: sel_ready = i_shift_ready;
      default:    sel_ready = 1'b0;
    endcase
  end

  assign issue = not_empty && !hazard && sel_ready && !i_flush;
  assign enq   = i_in_valid && o_in_ready && (i_in_unit != UNIT_BAD) && !i_flush;

  // Pointer and occupancy next-state; flush returns everything to empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)   tail_d = tail_q + PW'(1);
      if (issue) head_d = head_q + PW'(1);
      case ({enq, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers, occupancy and scoreboard.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // Entry write at the tail; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      uop_mem_q[tail_q]   <= i_in_uop;
      unit_mem_q[tail_q]  <= i_in_unit;
      rd_mem_q[tail_q]    <= i_in_rd;
      rs1_mem_q[tail_q]   <= i_in_rs1;
      rs2_mem_q[tail_q]   <= i_in_rs2;
      rd_en_mem_q[tail_q] <= i_in_rd_en;
    end
  end

endmodule

// File: tb/tb_warp_issue_queue.sv
// Directed self-checking bench for warp_issue_queue (default parameters).
module tb_warp_issue_queue;

  localparam int DEPTH = 8;
  localparam int UOP_W = 64;
  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int CW    = 4;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [UOP_W-1:0] i_in_uop;
  logic [1:0]       i_in_unit;
  logic [RW-1:0]    i_in_rd;
  logic [RW-1:0]    i_in_rs1;
  logic [RW-1:0]    i_in_rs2;
  logic             i_in_rd_en;
  logic             o_arith_valid;
  logic             o_logic_valid;
  logic             o_shift_valid;
  logic             i_arith_ready;
  logic             i_logic_ready;
  logic             i_shift_ready;
  logic [UOP_W-1:0] o_issue_uop;
  logic             i_wb_valid;
  logic [RW-1:0]    i_wb_rd;
  logic             i_flush;
  logic [CW-1:0]    o_count;

  int checks = 0;
  int errors = 0;

  warp_issue_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W), .NREGS(NREGS)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_uop      (i_in_uop),
    .i_in_unit     (i_in_unit),
    .i_in_rd       (i_in_rd),
    .i_in_rs1      (i_in_rs1),
    .i_in_rs2      (i_in_rs2),
    .i_in_rd_en    (i_in_rd_en),
    .o_arith_valid (o_arith_valid),
    .o_logic_valid (o_logic_valid),
    .o_shift_valid (o_shift_valid),
    .i_arith_ready (i_arith_ready),
    .i_logic_ready (i_logic_ready),
    .i_shift_ready (i_shift_ready),
    .o_issue_uop   (o_issue_uop),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .i_flush       (i_flush),
    .o_count       (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] unit, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                     input logic [RW-1:0] rs2, input logic rd_en, input logic [UOP_W-1:0] uop);
    i_in_valid = 1'b1;
    i_in_unit  = unit;
    i_in_rd    = rd;
    i_in_rs1   = rs1;
    i_in_rs2   = rs2;
    i_in_rd_en = rd_en;
    i_in_uop   = uop;
    #1;
  endtask

  task automatic idle();
    i_in_valid = 1'b0;
    i_in_uop   = '0;
    i_in_unit  = 2'd0;
    i_in_rd    = '0;
    i_in_rs1   = '0;
    i_in_rs2   = '0;
    i_in_rd_en = 1'b0;
    #1;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_arith_ready = 1'b0;
    i_logic_ready = 1'b0;
    i_shift_ready = 1'b0;
    i_wb_valid    = 1'b0;
    i_wb_rd       = '0;
    i_flush       = 1'b0;
    idle();
    #2;

    // Reset state
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_in_ready", 64'(o_in_ready), 64'd1);
    chk("rst_arith_valid", 64'(o_arith_valid), 64'd0);
    chk("rst_logic_valid", 64'(o_logic_valid), 64'd0);
    chk("rst_shift_valid", 64'(o_shift_valid), 64'd0);
    chk("rst_uop", o_issue_uop, 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Fill 8 arith uops rd=1..8 while the unit is not ready
    for (int i = 0; i < DEPTH; i++) begin
      enq(2'd0, RW'(i + 1), '0, '0, 1'b1, 64'hA000 + 64'(i + 1));
      chk($sformatf("fill_count_%0d", i), 64'(o_count), 64'(i));
      chk($sformatf("fill_ready_%0d", i), 64'(o_in_ready), 64'd1);
      tick();
    end
    enq(2'd0, '0, '0, '0, 1'b0, 64'hA0FF);
    chk("full_in_ready", 64'(o_in_ready), 64'd0);
    chk("full_count", 64'(o_count), 64'd8);
    chk("full_arith_valid", 64'(o_arith_valid), 64'd1);
    chk("full_head_uop", o_issue_uop, 64'hA001);
    tick();
    chk("full_drop_count", 64'(o_count), 64'd8);

    // Drain in order, one per cycle
    idle();
    i_arith_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk($sformatf("drain_uop_%0d", i), o_issue_uop, 64'hA001 + 64'(i));
      chk($sformatf("drain_count_%0d", i), 64'(o_count), 64'(DEPTH - i));
      tick();
    end
    chk("drain_count_end", 64'(o_count), 64'd0);
    chk("drain_valid_end", 64'(o_arith_valid), 64'd0);
    chk("drain_uop_end", o_issue_uop, 64'd0);
    i_arith_ready = 1'b0;

    // Release registers 1..8
    i_wb_valid = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      i_wb_rd = RW'(r);
      tick();
    end
    i_wb_valid = 1'b0;
    i_wb_rd    = '0;

    // RAW dependency on rd=5
    enq(2'd0, RW'(5), '0, '0, 1'b1, 64'hB1);
    tick();
    enq(2'd0, '0, RW'(5), '0, 1'b0, 64'hB2);
    i_arith_ready = 1'b1;
    #1;
    chk("raw_prod_valid", 64'(o_arith_valid), 64'd1);
    chk("raw_prod_uop", o_issue_uop, 64'hB1);
    tick();
    idle();
    chk("raw_stall_valid0", 64'(o_arith_valid), 64'd0);
    chk("raw_stall_count", 64'(o_count), 64'd1);
    chk("raw_stall_uop", o_issue_uop, 64'hB2);
    tick();
    chk("raw_stall_valid1", 64'(o_arith_valid), 64'd0);
    i_wb_valid = 1'b1;
    i_wb_rd    = RW'(5);
    #1;
`ifdef WARP_ISSUE_WB_BYPASS_EN
    chk("raw_wb_cycle_valid", 64'(o_arith_valid), 64'd1);
`else
    chk("raw_wb_cycle_valid", 64'(o_arith_valid), 64'd0);
`endif
    tick();
    i_wb_valid = 1'b0;
    i_wb_rd    = '0;
    #1;
`ifdef WARP_ISSUE_WB_BYPASS_EN
    chk("raw_after_wb_count", 64'(o_count), 64'd0);
`else
    chk("raw_after_wb_valid", 64'(o_arith_valid), 64'd1);
    chk("raw_after_wb_count", 64'(o_count), 64'd1);
    tick();
    chk("raw_late_count", 64'(o_count), 64'd0);
`endif
    i_arith_ready = 1'b0;

    // Logic head stalled by unit ready
    enq(2'd1, '0, '0, '0, 1'b0, 64'hC1);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lstall_logic_%0d", k), 64'(o_logic_valid), 64'd1);
      chk($sformatf("lstall_arith_%0d", k), 64'(o_arith_valid), 64'd0);
      chk($sformatf("lstall_shift_%0d", k), 64'(o_shift_valid), 64'd0);
      chk($sformatf("lstall_uop_%0d", k), o_issue_uop, 64'hC1);
      chk($sformatf("lstall_count_%0d", k), 64'(o_count), 64'd1);
      tick();
    end
    i_logic_ready = 1'b1;
    #1;
    chk("lrel_valid", 64'(o_logic_valid), 64'd1);
    tick();
    i_logic_ready = 1'b0;
    chk("lrel_count", 64'(o_count), 64'd0);

    // Shift unit routing
    enq(2'd2, '0, '0, '0, 1'b0, 64'hD1);
    tick();
    idle();
    chk("shift_valid", 64'(o_shift_valid), 64'd1);
    chk("shift_arith_valid", 64'(o_arith_valid), 64'd0);
    i_shift_ready = 1'b1;
    tick();
    i_shift_ready = 1'b0;
    chk("shift_count", 64'(o_count), 64'd0);

    // Illegal unit dropped
    enq(2'd3, '0, '0, '0, 1'b0, 64'h33);
    chk("bad_in_ready", 64'(o_in_ready), 64'd1);
    tick();
    idle();
    chk("bad_count", 64'(o_count), 64'd0);

    // rd=0 never marks busy
    enq(2'd0, '0, '0, '0, 1'b1, 64'hE1);
    tick();
    enq(2'd0, '0, '0, '0, 1'b0, 64'hE2);
    i_arith_ready = 1'b1;
    #1;
    chk("r0_first_valid", 64'(o_arith_valid), 64'd1);
    tick();
    idle();
    chk("r0_follow_valid", 64'(o_arith_valid), 64'd1);
    chk("r0_follow_uop", o_issue_uop, 64'hE2);
    tick();
    chk("r0_count", 64'(o_count), 64'd0);

    // Mark register 7 busy for the flush test
    enq(2'd0, RW'(7), '0, '0, 1'b1, 64'hE7);
    tick();
    idle();
    tick();
    chk("r7_issued_count", 64'(o_count), 64'd0);
    i_arith_ready = 1'b0;

    // Four entries with tail wrapping past index 7, then flush with enqueue
    for (int i = 0; i < 4; i++) begin
      enq(2'd0, '0, '0, '0, 1'b0, 64'hF0 + 64'(i));
      tick();
    end
    enq(2'd0, '0, '0, '0, 1'b0, 64'hF9);
    i_flush       = 1'b1;
    i_arith_ready = 1'b1;
    #1;
    chk("flush_pre_count", 64'(o_count), 64'd4);
    tick();
    i_flush       = 1'b0;
    i_arith_ready = 1'b0;
    idle();
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_arith_valid), 64'd0);
    chk("flush_uop", o_issue_uop, 64'd0);
    enq(2'd0, '0, RW'(7), '0, 1'b0, 64'hFA);
    tick();
    idle();
    chk("flush_busy_kept_valid", 64'(o_arith_valid), 64'd0);
    chk("flush_busy_kept_count", 64'(o_count), 64'd1);
    chk("flush_busy_kept_uop", o_issue_uop, 64'hFA);
    i_wb_valid = 1'b1;
    i_wb_rd    = RW'(7);
    tick();
    i_wb_valid = 1'b0;
    i_wb_rd    = '0;
    #1;
    chk("flush_wb_valid", 64'(o_arith_valid), 64'd1);
    i_arith_ready = 1'b1;
    tick();
    i_arith_ready = 1'b0;
    chk("flush_wb_count", 64'(o_count), 64'd0);

    // Reset mid-transfer clears entries and scoreboard
    enq(2'd0, RW'(12), '0, '0, 1'b1, 64'h12);
    i_arith_ready = 1'b1;
    tick();
    idle();
    tick();
    i_arith_ready = 1'b0;
    enq(2'd0, '0, '0, '0, 1'b0, 64'h99);
    tick();
    tick();
    idle();
    chk("prerst_count", 64'(o_count), 64'd2);
    i_rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_in_ready", 64'(o_in_ready), 64'd1);
    chk("arst_arith_valid", 64'(o_arith_valid), 64'd0);
    chk("arst_uop", o_issue_uop, 64'd0);
    tick();
    i_rst_n = 1'b1;
    enq(2'd0, '0, RW'(12), '0, 1'b0, 64'h66);
    tick();
    idle();
    chk("postrst_valid", 64'(o_arith_valid), 64'd1);
    chk("postrst_uop", o_issue_uop, 64'h66);
    chk("postrst_count", 64'(o_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
